// File: rtl/mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_pkg : shared types and constants for the MEM-stage access controller |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'h0000_0003;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return |(addr & WORD_ALIGN_MASK);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_access_stage : load/store req/ack controller with pipeline stall     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int          TIMEOUT  = 16,
  parameter int          CNT_W    = 5,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] ALUresult_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] ReadMem_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_rdata;
  logic             r_err;
  logic             r_req;
  logic             r_we;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;

  logic             w_acc;
  logic             w_misaligned;

  assign w_acc        = MemRead_i | MemWrite_i;
  assign w_misaligned = is_misaligned(ALUresult_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_acc) begin
            if (w_misaligned) begin
              r_err   <= 1'b1;
              r_state <= DONE;
            end else begin
              // MemWrite wins when both bits are set
              r_addr  <= ALUresult_i;
              r_wdata <= WriteData_i;
              r_we    <= MemWrite_i;
              r_req   <= 1'b1;
              r_cnt   <= '0;
              r_state <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_ack_i) begin
            r_req   <= 1'b0;
            if (!r_we) r_rdata <= mem_rdata_i;
            r_state <= DONE;
          end else if (r_cnt == c_cnt_last) begin
            r_req   <= 1'b0;
            r_err   <= 1'b1;
            if (!r_we) r_rdata <= ERR_DATA;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          // Pipeline advances this cycle; no new access may begin here.
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign stall_o     = ((r_state == IDLE) && w_acc) || (r_state == REQ);
  assign ReadMem_o   = r_rdata;
  assign err_o       = r_err;
  assign mem_req_o   = r_req;
  assign mem_we_o    = r_we;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_access_stage : scoreboard bench for mem_access_stage              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_mem_access_stage;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          stalls;
    int          gap;     // -1 = don't care
  } rel_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          len;
  } req_t;

  logic        clk_i;
  logic        rst_i;
  logic        MemRead_i;
  logic        MemWrite_i;
  logic [31:0] ALUresult_i;
  logic [31:0] WriteData_i;
  logic [31:0] ReadMem_o;
  logic        stall_o;
  logic        err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        resp_ack;
  logic        stray_ack;
  logic [31:0] mem_rdata_i;

  int          n_checks;
  int          n_fail;
  int          ack_delay;
  logic [31:0] resp_rdata;

  rel_t        rel_q[$];
  req_t        req_q[$];

  mem_access_stage #(
    .TIMEOUT (16),
    .CNT_W   (5),
    .ERR_DATA(32'hDEADBEEF)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .MemRead_i  (MemRead_i),
    .MemWrite_i (MemWrite_i),
    .ALUresult_i(ALUresult_i),
    .WriteData_i(WriteData_i),
    .ReadMem_o  (ReadMem_o),
    .stall_o    (stall_o),
    .err_o      (err_o),
    .mem_req_o  (mem_req_o),
    .mem_we_o   (mem_we_o),
    .mem_addr_o (mem_addr_o),
    .mem_wdata_o(mem_wdata_o),
    .mem_ack_i  (resp_ack | stray_ack),
    .mem_rdata_i(mem_rdata_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack after ack_delay REQ cycles (-1 = never).
  initial begin
    int age;
    age         = 0;
    resp_ack    = 1'b0;
    mem_rdata_i = 32'hFFFF0000;
    forever begin
      @(posedge clk_i); #1;
      resp_ack    = 1'b0;
      mem_rdata_i = 32'hFFFF0000;
      if (mem_req_o) begin
        if (ack_delay >= 0 && age == ack_delay) begin
          resp_ack    = 1'b1;
          mem_rdata_i = resp_rdata;
        end
        age++;
      end else begin
        age = 0;
      end
    end
  end

  // Monitor: release events (stall run ending) and request windows.
  initial begin
    int   cnt, gap, run_gap, req_len;
    logic req_active;
    rel_t r;
    req_t q;
    cnt = 0; gap = 0; run_gap = 0; req_len = 0; req_active = 1'b0;
    q   = '{addr: 32'h0, we: 1'b0, wdata: 32'h0, len: 0};
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        cnt = 0; gap = 0; req_active = 1'b0;
      end else begin
        if (stall_o) begin
          if (cnt == 0) run_gap = gap;
          cnt++;
        end else if (cnt > 0) begin
          if (rel_q.size() == 0) begin
            check("unexpected_release", 32'(cnt), 32'(0));
          end else begin
            r = rel_q.pop_front();
            check("rel_rdata",  ReadMem_o,   r.rdata);
            check("rel_err",    32'(err_o),  32'(r.err));
            check("rel_stalls", 32'(cnt),    32'(r.stalls));
            if (r.gap >= 0) check("rel_gap", 32'(run_gap), 32'(r.gap));
          end
          cnt = 0;
          gap = 1;
        end else begin
          gap++;
        end

        if (mem_req_o && !req_active) begin
          if (req_q.size() == 0) begin
            check("unexpected_req", mem_addr_o, 32'hFFFFFFFF);
          end else begin
            q = req_q.pop_front();
            check("req_addr",  mem_addr_o,      q.addr);
            check("req_we",    32'(mem_we_o),   32'(q.we));
            check("req_wdata", mem_wdata_o,     q.wdata);
          end
          req_active = 1'b1;
          req_len    = 1;
        end else if (mem_req_o) begin
          req_len++;
          if (mem_addr_o !== q.addr || mem_wdata_o !== q.wdata || mem_we_o !== q.we)
            check("req_stable", mem_addr_o, q.addr);
        end else if (req_active) begin
          if (q.len >= 0) check("req_len", 32'(req_len), 32'(q.len));
          req_active = 1'b0;
        end
      end
    end
  end

  // Issue one access and hold it until the pipeline is released.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int dly, input logic [31:0] rdata);
    int n;
    ack_delay   = dly;
    resp_rdata  = rdata;
    MemRead_i   = rd;
    MemWrite_i  = wr;
    ALUresult_i = addr;
    WriteData_i = wdata;
    n = 0;
    do begin
      @(posedge clk_i); #1;
      n++;
    end while (stall_o && n < 100);
    if (n >= 100) check("release_wait_bound", 32'(n), 32'(0));
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    ack_delay = -1; resp_rdata = 32'h0; stray_ack = 1'b0;
    rst_i = 1'b1; MemRead_i = 1'b0; MemWrite_i = 1'b0;
    ALUresult_i = 32'h0; WriteData_i = 32'h0;
    idle_cycles(2);
    rst_i = 1'b0;
    idle_cycles(1);

    check("rst_readmem", ReadMem_o,          32'h0);
    check("rst_err",     32'(err_o),         32'h0);
    check("rst_req",     32'(mem_req_o),     32'h0);
    check("rst_we",      32'(mem_we_o),      32'h0);
    check("rst_addr",    mem_addr_o,         32'h0);
    check("rst_wdata",   mem_wdata_o,        32'h0);
    check("rst_stall",   32'(stall_o),       32'h0);

    // Load, immediate ack
    req_q.push_back('{addr: 32'h100, we: 1'b0, wdata: 32'h0, len: 1});
    rel_q.push_back('{rdata: 32'h12345678, err: 1'b0, stalls: 2, gap: -1});
    do_access(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'h12345678);
    idle_cycles(2);

    // Store, ack after 3 extra cycles; read data on the bus must be ignored
    req_q.push_back('{addr: 32'h20, we: 1'b1, wdata: 32'hCAFEF00D, len: 4});
    rel_q.push_back('{rdata: 32'h12345678, err: 1'b0, stalls: 5, gap: -1});
    do_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 3, 32'hBAD0BAD0);
    idle_cycles(2);

    // Both bits set -> store
    req_q.push_back('{addr: 32'h44, we: 1'b1, wdata: 32'h11112222, len: 2});
    rel_q.push_back('{rdata: 32'h12345678, err: 1'b0, stalls: 3, gap: -1});
    do_access(1'b1, 1'b1, 32'h44, 32'h11112222, 1, 32'h77778888);
    idle_cycles(2);

    // Stray ack while IDLE
    mem_rdata_i = 32'h55555555;
    stray_ack   = 1'b1;
    @(posedge clk_i); #1;
    stray_ack   = 1'b0;
    idle_cycles(1);
    check("stray_req",     32'(mem_req_o), 32'h0);
    check("stray_stall",   32'(stall_o),   32'h0);
    check("stray_readmem", ReadMem_o,      32'h12345678);
    check("stray_err",     32'(err_o),     32'h0);

    // Back-to-back loads, one DONE cycle between them
    req_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0, len: 1});
    rel_q.push_back('{rdata: 32'hA5A5A5A5, err: 1'b0, stalls: 2, gap: -1});
    req_q.push_back('{addr: 32'h204, we: 1'b0, wdata: 32'h0, len: 1});
    rel_q.push_back('{rdata: 32'h5A5A5A5A, err: 1'b0, stalls: 2, gap: 1});
    do_access(1'b1, 1'b0, 32'h200, 32'h0, 0, 32'hA5A5A5A5);
    do_access(1'b1, 1'b0, 32'h204, 32'h0, 0, 32'h5A5A5A5A);
    idle_cycles(2);

    // Misaligned load: no request, one stall cycle, data unchanged
    rel_q.push_back('{rdata: 32'h5A5A5A5A, err: 1'b1, stalls: 1, gap: -1});
    do_access(1'b1, 1'b0, 32'h103, 32'h0, 0, 32'h99999999);
    idle_cycles(2);

    // Timeout
    req_q.push_back('{addr: 32'h300, we: 1'b0, wdata: 32'h0, len: 16});
    rel_q.push_back('{rdata: 32'hDEADBEEF, err: 1'b1, stalls: 17, gap: -1});
    do_access(1'b1, 1'b0, 32'h300, 32'h0, -1, 32'h0);
    idle_cycles(2);

    // err stays sticky through a good load
    req_q.push_back('{addr: 32'h10, we: 1'b0, wdata: 32'h0, len: 1});
    rel_q.push_back('{rdata: 32'h01020304, err: 1'b1, stalls: 2, gap: -1});
    do_access(1'b1, 1'b0, 32'h10, 32'h0, 0, 32'h01020304);
    idle_cycles(2);

    // Reset in the middle of an outstanding request
    req_q.push_back('{addr: 32'h40, we: 1'b0, wdata: 32'h0, len: -1});
    ack_delay   = -1;
    MemRead_i   = 1'b1;
    ALUresult_i = 32'h40;
    idle_cycles(3);
    check("midreq_req_high", 32'(mem_req_o), 32'h1);
    rst_i     = 1'b1;
    MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    check("midreq_req",     32'(mem_req_o), 32'h0);
    check("midreq_readmem", ReadMem_o,      32'h0);
    check("midreq_err",     32'(err_o),     32'h0);
    check("midreq_stall",   32'(stall_o),   32'h0);
    idle_cycles(2);

    // Recovery after reset
    req_q.push_back('{addr: 32'h80, we: 1'b0, wdata: 32'h0, len: 3});
    rel_q.push_back('{rdata: 32'h0BADF00D, err: 1'b0, stalls: 4, gap: -1});
    do_access(1'b1, 1'b0, 32'h80, 32'h0, 2, 32'h0BADF00D);
    idle_cycles(3);

    check("rel_q_drained", 32'(rel_q.size()), 32'h0);
    check("req_q_drained", 32'(req_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage access controller between the EX/MEM pipeline register and the MEM/WB register.
- Converts the load/store control bits and the ALU-computed address into a req/ack transaction on a variable-latency data-memory port.
- Stalls the pipeline while an access is outstanding.
- Presents the load data to MEM/WB on the cycle the pipeline is released.

Parameters:
- TIMEOUT, 16, max cycles in REQ waiting for mem_ack_i before abort (>=1)
- CNT_W, 5, timeout counter width; must hold TIMEOUT
- ERR_DATA, 32'hDEADBEEF, load value returned on timeout

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, synchronous, active-high
- MemRead_i  in  1  load request from EX/MEM
- MemWrite_i  in  1  store request from EX/MEM
- ALUresult_i  in  32  byte address
- WriteData_i  in  32  store data
- ReadMem_o  out  32  load data to MEM/WB
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM; bubble not inserted into MEM/WB here
- err_o  out  1  sticky: misaligned access or timeout seen
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1 = write
- mem_addr_o  out  32  word-aligned address
- mem_wdata_o  out  32  write data
- mem_ack_i  in  1  memory completion, one-cycle pulse
- mem_rdata_i  in  32  read data, valid with mem_ack_i

Behaviour:
- Reset (rst_i=1 at posedge):
  - state=IDLE; ReadMem_o=0; err_o=0; mem_req_o=0; mem_we_o=0; mem_addr_o=0; mem_wdata_o=0; counter=0.
  - Overrides any in-flight access; the request drops on the next edge.
- States:
  - IDLE
  - REQ
  - DONE
- acc = MemRead_i | MemWrite_i. If both bits are set, the access is a store (MemWrite priority).
- IDLE:
  - acc=0: stay in IDLE.
  - acc=1, ALUresult_i[1:0]!=0: no request; set err_o; go to DONE; ReadMem_o unchanged.
  - acc=1, aligned: register mem_addr_o=ALUresult_i, mem_wdata_o=WriteData_i, mem_we_o=MemWrite_i; set mem_req_o=1; counter=0; go to REQ.
- REQ:
  - mem_req_o and the address/data/we outputs are held stable until ack or abort.
  - mem_ack_i=1: mem_req_o=0. On a read, ReadMem_o<=mem_rdata_i. Go to DONE.
  - No ack, counter==TIMEOUT-1: abort. mem_req_o=0; err_o=1; ReadMem_o<=ERR_DATA if read. Go to DONE.
  - Otherwise counter++ and stay in REQ.
- DONE:
  - stall_o=0, so the pipeline advances at this edge and MEM/WB captures ReadMem_o.
  - Unconditionally return to IDLE; a new access cannot start in DONE.
- stall_o is combinational: (IDLE & acc) | REQ. It is 0 in DONE and in IDLE with no access.
- ReadMem_o holds its value between loads; stores never modify it.
- mem_ack_i outside REQ is ignored and has no state effect.
- Latency:
  - ack on the first REQ cycle gives 2 stall cycles; the instruction leaves the MEM stage on cycle 3.
  - Each extra ack-wait cycle adds 1 stall cycle.
  - Misaligned access gives 1 stall cycle.
- err_o clears only on reset.

Decomposition:
- Shared package mem_pkg:
  - state enum {IDLE, REQ, DONE}
  - ERR_DATA default
  - word-alignment mask constant
- No sub-module: the FSM, timeout counter and output registers stay in one module.
- Integrate with the hazard unit by ORing stall_o into its stall.

Test Plan:
- Reset mid-REQ: rst_i pulsed while REQ at addr 0x40 -> next cycle mem_req_o=0, state IDLE, ReadMem_o=0, err_o=0.
- Load, immediate ack: MemRead_i=1, ALUresult_i=0x100, ack with rdata 0x12345678 on first REQ cycle -> stall_o=1 for exactly 2 cycles, then ReadMem_o=0x12345678 with stall_o=0.
- Store, 3-cycle ack delay: MemWrite_i=1, addr 0x20, data 0xCAFEF00D -> mem_we_o=1, addr/data stable through 4 REQ cycles; stall 5 cycles; ReadMem_o unchanged.
- Misaligned: MemRead_i=1, addr 0x103 -> mem_req_o never 1, err_o=1, stall_o=1 for 1 cycle.
- Timeout: MemRead_i=1, no ack, TIMEOUT=16 -> mem_req_o high exactly 16 cycles, then ReadMem_o=0xDEADBEEF, err_o=1.
- Both bits plus stray ack: MemRead_i=MemWrite_i=1 -> store issued; an ack pulse in IDLE is ignored; back-to-back loads separated by exactly one DONE cycle.
